// File: rtl/ext_defs.sv
// Shared definitions for the immediate extender: opcode encodings and widths.
package ext_defs;

   localparam int unsigned EOP_W = 3;

   typedef enum logic [EOP_W-1:0] {
      EOP_SEXT     = 3'd0,
      EOP_ZEXT     = 3'd1,
      EOP_LUI      = 3'd2,
      EOP_SEXT_SHL = 3'd3,
      EOP_ZEXT_SHL = 3'd4
   } eop_e;

   // Last legal opcode; anything above is flagged illegal.
   localparam logic [EOP_W-1:0] EOP_MAX = 3'd4;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign/zero/upper placement with optional left shift.
module imm_ext_core
   import ext_defs::*;
#(
   parameter int unsigned IMM_W    = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned BR_SHIFT = 2
) (
   input  logic [IMM_W-1:0]  imm,
   input  logic [EOP_W-1:0]  eop,
   output logic [DATA_W-1:0] ext,
   output logic              illegal
);

   logic [DATA_W-1:0] w_sext;
   logic [DATA_W-1:0] w_zext;
   logic [DATA_W-1:0] w_lui;

   assign w_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   assign w_zext = {{(DATA_W-IMM_W){1'b0}}, imm};
   assign w_lui  = {imm, {(DATA_W-IMM_W){1'b0}}};

   always_comb begin
      ext     = '0;
      illegal = 1'b0;
      case (eop_e'(eop))
         EOP_SEXT:     ext = w_sext;
         EOP_ZEXT:     ext = w_zext;
         EOP_LUI:      ext = w_lui;
         EOP_SEXT_SHL: ext = w_sext << BR_SHIFT;
         EOP_ZEXT_SHL: ext = w_zext << BR_SHIFT;
         default:      illegal = 1'b1;
      endcase
      if (eop > EOP_MAX) begin
         ext     = '0;
         illegal = 1'b1;
      end
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with valid/ready handshake, 2-entry skid buffer,
// illegal-opcode error counter and synchronous flush.
module imm_ext_pipe
   import ext_defs::*;
#(
   parameter int unsigned IMM_W    = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned BR_SHIFT = 2,
   parameter int unsigned TAG_W    = 32,
   parameter int unsigned CNT_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [EOP_W-1:0]  in_eop,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_ext,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err,
   output logic [CNT_W-1:0]  err_cnt
);

   logic [DATA_W-1:0] w_ext;
   logic              w_illegal;
   logic              w_acc;
   logic              w_drain;

   logic              r_main_valid;
   logic [DATA_W-1:0] r_main_ext;
   logic [TAG_W-1:0]  r_main_tag;
   logic              r_main_err;

   logic              r_skid_valid;
   logic [DATA_W-1:0] r_skid_ext;
   logic [TAG_W-1:0]  r_skid_tag;
   logic              r_skid_err;

   logic [CNT_W-1:0]  r_cnt;

   imm_ext_core #(
      .IMM_W    (IMM_W),
      .DATA_W   (DATA_W),
      .BR_SHIFT (BR_SHIFT)
   ) u_core (
      .imm     (in_imm),
      .eop     (in_eop),
      .ext     (w_ext),
      .illegal (w_illegal)
   );

   assign in_ready  = !r_skid_valid && !reset;
   assign w_acc     = in_valid && in_ready;
   assign w_drain   = r_main_valid && out_ready;

   assign out_valid = r_main_valid;
   assign out_ext   = r_main_ext;
   assign out_tag   = r_main_tag;
   assign out_err   = r_main_err;
   assign err_cnt   = r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_main_valid <= 1'b0;
         r_main_ext   <= '0;
         r_main_tag   <= '0;
         r_main_err   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_ext   <= '0;
         r_skid_tag   <= '0;
         r_skid_err   <= 1'b0;
         r_cnt        <= '0;
      end else if (flush) begin
         // Entry presented during flush is dropped and not counted.
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else begin
         if (w_acc && w_illegal && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;

         if (!r_main_valid || w_drain) begin
            if (r_skid_valid) begin
               r_main_valid <= 1'b1;
               r_main_ext   <= r_skid_ext;
               r_main_tag   <= r_skid_tag;
               r_main_err   <= r_skid_err;
               r_skid_valid <= 1'b0;
            end else if (w_acc) begin
               r_main_valid <= 1'b1;
               r_main_ext   <= w_ext;
               r_main_tag   <= in_tag;
               r_main_err   <= w_illegal;
            end else begin
               r_main_valid <= 1'b0;
            end
         end else if (w_acc) begin
            r_skid_valid <= 1'b1;
            r_skid_ext   <= w_ext;
            r_skid_tag   <= in_tag;
            r_skid_err   <= w_illegal;
         end
      end
   end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: scoreboard on the output handshake plus per-scenario checks.
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_imm = '0;
   logic [2:0]  in_eop = '0;
   logic [31:0] in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_ext;
   logic [31:0] out_tag;
   logic        out_err;
   logic [1:0]  err_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] ext;
      logic [31:0] tag;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;

   imm_ext_pipe #(.CNT_W(2)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_eop    (in_eop),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ext   (out_ext),
      .out_tag   (out_tag),
      .out_err   (out_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [2:0] eop);
      case (eop)
         3'd0:    return {{16{imm[15]}}, imm};
         3'd1:    return {16'h0000, imm};
         3'd2:    return {imm, 16'h0000};
         3'd3:    return {{14{imm[15]}}, imm, 2'b00};
         3'd4:    return {14'h0000, imm, 2'b00};
         default: return 32'h0;
      endcase
   endfunction

   function automatic exp_t model(input logic [15:0] imm, input logic [2:0] eop, input logic [31:0] tag);
      exp_t e;
      e.ext = model_ext(imm, eop);
      e.tag = tag;
      e.err = (eop >= 3'd5);
      return e;
   endfunction

   // Every consumed output is checked against the scoreboard in acceptance order.
   always @(negedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got ext=%h tag=%h err=%b, required no output", out_ext, out_tag, out_err);
         end else begin
            m_e = sb.pop_front();
            if (out_ext !== m_e.ext || out_tag !== m_e.tag || out_err !== m_e.err) begin
               n_fail++;
               $display("FAIL sb_entry: got ext=%h tag=%h err=%b, required ext=%h tag=%h err=%b",
                        out_ext, out_tag, out_err, m_e.ext, m_e.tag, m_e.err);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the entry is accepted.
   task automatic send(input logic [15:0] imm, input logic [2:0] eop, input logic [31:0] tag);
      bit done = 0;
      in_valid = 1'b1; in_imm = imm; in_eop = eop; in_tag = tag;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(model(imm, eop, tag));
            done = 1;
         end
         @(posedge clk); #1;
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: got in_ready=0 for 20 cycles, required acceptance tag=%h", tag);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain_sb();
      for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d entries pending, required 0", sb.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || out_ext !== 32'h0 || out_tag !== 32'h0 || out_err !== 1'b0 || err_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b ext=%h tag=%h err=%b cnt=%0d, required all 0",
                  out_valid, out_ext, out_tag, out_err, err_cnt);
      end
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b, required 0", in_ready);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b, required 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sext();
      out_ready = 1'b1;
      send(16'h8000, 3'd0, 32'h0000_1000);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_ext !== 32'hFFFF8000 || out_err !== 1'b0) begin
         n_fail++;
         $display("FAIL sext_neg: got v=%b ext=%h err=%b, required v=1 ext=ffff8000 err=0", out_valid, out_ext, out_err);
      end
      @(posedge clk); #1;
      send(16'h7FFF, 3'd0, 32'h0000_1004);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_ext !== 32'h00007FFF) begin
         n_fail++;
         $display("FAIL sext_pos: got v=%b ext=%h, required v=1 ext=00007fff", out_valid, out_ext);
      end
      @(posedge clk); #1;
      drain_sb();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_ext [4];
      exp_ext[0] = 32'h0000FFFC; exp_ext[1] = 32'hFFFC0000;
      exp_ext[2] = 32'hFFFFFFF0; exp_ext[3] = 32'h0003FFF0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            in_valid = 1'b1; in_imm = 16'hFFFC; in_eop = 3'(i + 1); in_tag = 32'h2000 + 32'(i);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (i < 4) begin
            n_tests++;
            if (in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_ready[%0d]: got %b, required 1", i, in_ready);
            end
            sb.push_back(model(16'hFFFC, 3'(i + 1), 32'h2000 + 32'(i)));
         end
         if (i > 0) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_ext !== exp_ext[i-1] || out_tag !== 32'h2000 + 32'(i - 1)) begin
               n_fail++;
               $display("FAIL b2b_out[%0d]: got v=%b ext=%h tag=%h, required v=1 ext=%h tag=%h",
                        i - 1, out_valid, out_ext, out_tag, exp_ext[i-1], 32'h2000 + 32'(i - 1));
            end
         end
         @(posedge clk); #1;
      end
      drain_sb();
   endtask

   task automatic test_backpressure();
      bit got = 0;
      out_ready = 1'b0;
      send(16'h1234, 3'd0, 32'hA);
      send(16'h8001, 3'd3, 32'hB);
      in_valid = 1'b1; in_imm = 16'h00F0; in_eop = 3'd2; in_tag = 32'hC;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_ext !== 32'h00001234 || out_tag !== 32'hA) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got rdy=%b v=%b ext=%h tag=%h, required rdy=0 v=1 ext=00001234 tag=a",
                     k, in_ready, out_valid, out_ext, out_tag);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(model(16'h00F0, 3'd2, 32'hC));
            got = 1;
         end
         n_tests++;
         if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_gap[%0d]: got out_valid=%b, required 1", k, out_valid);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL bp_accept_c: got in_ready=0 for 10 cycles, required acceptance");
      end
      drain_sb();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      send(16'h0001, 3'd1, 32'hF1);
      send(16'h0002, 3'd1, 32'hF2);
      in_valid = 1'b1; in_imm = 16'h0003; in_eop = 3'd7; in_tag = 32'hF3;
      flush = 1'b1;
      sb.delete();
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 2'd0) begin
         n_fail++;
         $display("FAIL flush_full: got v=%b rdy=%b cnt=%0d, required v=0 rdy=1 cnt=0", out_valid, in_ready, err_cnt);
      end
      @(posedge clk); #1;
      // Empty buffer: in_ready is high, yet the flush-cycle entry must be dropped.
      in_valid = 1'b1; in_eop = 3'd7; in_tag = 32'hF4; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b0 || err_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL flush_empty[%0d]: got v=%b cnt=%0d, required v=0 cnt=0", k, out_valid, err_cnt);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(16'(32'h5A5A + 32'(i)), 3'd6, 32'h300 + 32'(i));
         @(negedge clk);
         n_tests++;
         if (err_cnt !== ((i < 3) ? 2'(i + 1) : 2'd3) || out_err !== 1'b1 || out_ext !== 32'h0) begin
            n_fail++;
            $display("FAIL illegal[%0d]: got cnt=%0d err=%b ext=%h, required cnt=%0d err=1 ext=0",
                     i, err_cnt, out_err, out_ext, (i < 3) ? i + 1 : 3);
         end
         @(posedge clk); #1;
      end
      send(16'h0010, 3'd0, 32'h3FF);
      @(negedge clk);
      n_tests++;
      if (out_err !== 1'b0 || err_cnt !== 2'd3) begin
         n_fail++;
         $display("FAIL illegal_after: got err=%b cnt=%0d, required err=0 cnt=3", out_err, err_cnt);
      end
      @(posedge clk); #1;
      drain_sb();
   endtask

   task automatic test_mid_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b0;
      send(16'h1111, 3'd5, 32'h401);
      send(16'h2222, 3'd6, 32'h402);
      @(negedge clk);
      n_tests++;
      if (err_cnt !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre: got cnt=%0d rdy=%b v=%b, required cnt=2 rdy=0 v=1", err_cnt, in_ready, out_valid);
      end
      @(posedge clk); #1;
      reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_eop = 3'd7; in_tag = 32'h403;
      sb.delete();
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst_ready: got %b, required 0", in_ready);
      end
      @(posedge clk); #1;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || out_ext !== 32'h0 || out_tag !== 32'h0 || out_err !== 1'b0 ||
          err_cnt !== 2'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_post: got v=%b ext=%h tag=%h err=%b cnt=%0d rdy=%b, required v=0 ext=0 tag=0 err=0 cnt=0 rdy=1",
                  out_valid, out_ext, out_tag, out_err, err_cnt, in_ready);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_sext();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_illegal();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
